lsu_mem_pipe: RTL and testbench
===============================

# lsu_mem_pipe

Execute stage of the load/store path: consumes one operand-resolved memory micro-op per issue from the LSU issue queue (after the one-cycle register-read stage).
- Computes the effective address and checks alignment.
- Drives a single-outstanding SRAM-like data-bus handshake, then writes load results back by physical register number.
- Produces `lsu_busy`, which gates LSU issue arbitration, so at most one memory op is in flight.

## Interface
Parameters:
- `PRF_W`, 6: physical register number width (matches `PRFNum`).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: pipeline flush; cancels the not-yet-accepted op.
- `req_valid` in 1: micro-op present from register-read.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is illegal (treated as word).
- `req_signed` in 1: load sign-extend.
- `req_base` in 32: rs value.
- `req_offset` in 16: immediate, sign-extended.
- `req_wdata` in 32: store data (rt value).
- `req_dst` in PRF_W: load destination.
- `req_dstwe` in 1: destination write enable.
- `lsu_busy` out 1: to the issue unit; blocks arbitration.
- `mem_req` out 1: bus request.
- `mem_we` out 1: write.
- `mem_addr` out 32: word-aligned address.
- `mem_wstrb` out 4: byte strobes.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_addr_ok` in 1: request accepted this cycle.
- `mem_data_ok` in 1: read data / write ack valid.
- `mem_rdata` in 32: read data.
- `wb_valid` out 1: writeback pulse.
- `wb_dst` out PRF_W: writeback register.
- `wb_data` out 32: extended load data.
- `exc_valid` out 1: address-error pulse.
- `exc_code` out 5: 4 = AdEL, 5 = AdES.
- `exc_badvaddr` out 32: faulting address.

## Operation
- Effective address: `ea = req_base + sext(req_offset)`, modulo 2^32.
- Misaligned when:
  - half with `ea[0]`;
  - word with `ea[1:0] != 0`.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - `req_valid && !flush`, aligned: latch `ea`, size, signed, dst, dstwe, store, strobes and data; go to REQ.
  - `req_valid && !flush`, misaligned: register `exc_valid = 1`, code 4 (load) or 5 (store), `exc_badvaddr = ea`; stay IDLE; no bus activity.
  - `req_valid && flush`: discard the op.
- REQ:
  - `mem_req = 1`; `mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata` are held stable until `mem_addr_ok`.
  - On `mem_addr_ok`: go to WAIT, or to DRAIN if `flush` is also asserted.
  - On `flush` without `mem_addr_ok`: go to IDLE; the request is withdrawn.
- WAIT:
  - On `mem_data_ok`: go to IDLE. A load with `dstwe` registers `wb_valid`/`wb_dst`/`wb_data`. A store produces no writeback.
  - On `flush` (with or without `mem_data_ok`): a `mem_data_ok` seen in the same cycle goes to IDLE with no writeback; otherwise go to DRAIN.
- DRAIN: wait for `mem_data_ok`, discard it, go to IDLE. Stores already accepted complete in memory; upstream only issues non-speculative stores.
- Store strobes:
  - byte: `0001 << ea[1:0]`, data `{4{wdata[7:0]}}`;
  - half: `0011 << ea[1:0]`, data `{2{wdata[15:0]}}`;
  - word: `1111`, data `wdata`.
- Load extraction:
  - byte lane `ea[1:0]`; half lane `ea[1]`;
  - sign- or zero-extend per `req_signed`.
- `mem_addr = {ea[31:2], 2'b00}`.

## Timing
- Reset: state IDLE; every output 0, including `lsu_busy`.
- `lsu_busy = (state != IDLE) | req_valid`, combinational.
  - An op issued at cycle t arrives at t+1 and blocks issue from t+1.
  - No back-to-back issue while an op is in the pipe.
- `mem_req` is first asserted the cycle after acceptance (t+2 relative to issue).
- `mem_data_ok` is never expected in the same cycle as `mem_addr_ok`; the earliest is the next cycle.
- `wb_valid` and `exc_valid` are single-cycle pulses, registered one cycle after the `mem_data_ok` / acceptance cycle.
  - Load with 0-wait memory: accept t, REQ+addr_ok t+1, data_ok t+2, `wb_valid` t+3, IDLE at t+3.
- `rst` mid-transaction returns to IDLE next cycle; the bus is assumed reset concurrently.

## Structure
- Shared package holds:
  - `LSU_Size` enum;
  - `LSU_Pipe_State` enum (IDLE/REQ/WAIT/DRAIN);
  - exception codes `EXC_ADEL` = 4, `EXC_ADES` = 5.
- Sub-module `lsu_align_unit` is purely combinational: size + `ea[1:0]` + wdata/rdata in, misalign/wstrb/wdata/extended rdata out.
- Top level holds the FSM and the output registers.

## Test plan
- Aligned `lw`, base 0x1000, off −4 → `mem_addr` 0xFFC, `wstrb` 0; `rdata` 0xDEADBEEF → `wb_data` 0xDEADBEEF, `wb_dst` = `req_dst`, one pulse.
- `lb` signed at ea 0x1003, `rdata` 0x80xxxxxx → `wb_data` 0xFFFFFF80. `lbu` at the same address → 0x00000080.
- `sh` at ea 0x2002, wdata 0x1234ABCD → `wstrb` 1100, `mem_wdata` 0xABCDABCD, `mem_we` 1, no `wb_valid`.
- `lw` at 0x3001 → `exc_valid` 1, code 4, badvaddr 0x3001, `mem_req` never asserted. `sw` at 0x3002 → code 5.
- `addr_ok` withheld 3 cycles → request fields stable and `lsu_busy` held 1. Then flush in REQ → `mem_req` 0 next cycle, IDLE.
- Flush in WAIT, `data_ok` 2 cycles later → no `wb_valid`, DRAIN then IDLE, `lsu_busy` drops the cycle after `data_ok`.

Source files
------------

// File: rtl/lsu_mem_pipe_pkg.sv
// lsu_mem_pipe_pkg
//   Shared types and constants for the load/store execute stage:
//   access size encoding, pipe FSM states and address-error codes.
package lsu_mem_pipe_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } LSU_Size;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } LSU_Pipe_State;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

endpackage

// File: rtl/lsu_align_unit.sv
// lsu_align_unit
//   Purely combinational lane logic for the LSU.
//   Ports:
//     size      in  2  : access size (LSU_Size encoding, 3 acts as word)
//     ea_lo     in  2  : low bits of the effective address
//     is_signed in  1  : sign-extend loaded byte/half
//     wdata     in  32 : raw store data
//     rdata     in  32 : raw bus read data
//     misalign  out 1  : access not naturally aligned
//     wstrb     out 4  : byte strobes for a store
//     wdata_ext out 32 : store data replicated across lanes
//     rdata_ext out 32 : selected lane, sign/zero extended
module lsu_align_unit
  import lsu_mem_pipe_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  ea_lo,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        misalign,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_ext,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_shift;
  logic [15:0] half_val;

  // Byte lanes are selected by shifting the word down; half lanes by ea[1].
  always_comb begin
    misalign    = 1'b0;
    wstrb       = 4'b1111;
    wdata_ext   = wdata;
    rdata_ext   = rdata;
    rdata_shift = rdata >> {ea_lo, 3'b000};
    half_val    = ea_lo[1] ? rdata[31:16] : rdata[15:0];
    case (LSU_Size'(size))
      SIZE_BYTE: begin
        wstrb     = 4'b0001 << ea_lo;
        wdata_ext = {4{wdata[7:0]}};
        rdata_ext = {{24{is_signed & rdata_shift[7]}}, rdata_shift[7:0]};
      end
      SIZE_HALF: begin
        misalign  = ea_lo[0];
        wstrb     = 4'b0011 << ea_lo;
        wdata_ext = {2{wdata[15:0]}};
        rdata_ext = {{16{is_signed & half_val[15]}}, half_val};
      end
      default: begin
        misalign = |ea_lo;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_pipe.sv
// lsu_mem_pipe
//   Execute stage of the load/store path. Computes the effective address,
//   raises address errors, runs a single-outstanding request/data bus
//   handshake and writes load results back by physical register number.
//   Ports:
//     clk, rst                  : clock, synchronous active-high reset
//     flush                     : cancel the op not yet accepted by memory
//     req_*                     : operand-resolved micro-op from register read
//     lsu_busy                  : blocks LSU issue arbitration
//     mem_req/we/addr/wstrb/wdata, mem_addr_ok/data_ok/rdata : data bus
//     wb_valid/dst/data         : load writeback pulse
//     exc_valid/code/badvaddr   : address-error pulse
module lsu_mem_pipe
  import lsu_mem_pipe_pkg::*;
#(
  parameter int PRF_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  input  logic             req_is_store,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_base,
  input  logic [15:0]      req_offset,
  input  logic [31:0]      req_wdata,
  input  logic [PRF_W-1:0] req_dst,
  input  logic             req_dstwe,
  output logic             lsu_busy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic             mem_data_ok,
  input  logic [31:0]      mem_rdata,
  output logic             wb_valid,
  output logic [PRF_W-1:0] wb_dst,
  output logic [31:0]      wb_data,
  output logic             exc_valid,
  output logic [4:0]       exc_code,
  output logic [31:0]      exc_badvaddr
);

  LSU_Pipe_State state, state_next;

  logic [31:0]      ea;
  logic [31:0]      ea_q;
  logic [1:0]       size_q;
  logic             signed_q;
  logic [PRF_W-1:0] dst_q;
  logic             dstwe_q;
  logic             store_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      wdata_q;

  logic             in_idle;
  logic             accept;
  logic             misalign;
  logic [3:0]       al_wstrb;
  logic [31:0]      al_wdata;
  logic [31:0]      al_rdata;
  logic             load_done;

  assign ea      = req_base + {{16{req_offset[15]}}, req_offset};
  assign in_idle = (state == ST_IDLE);
  assign accept  = in_idle & req_valid & ~flush;

  // One align unit serves both ends of an op: in IDLE it sees the incoming
  // request (alignment, strobes, store lanes); afterwards it sees the latched
  // op so the read data is extracted with the accepted size and offset.
  lsu_align_unit u_align (
    .size      (in_idle ? req_size   : size_q),
    .ea_lo     (in_idle ? ea[1:0]    : ea_q[1:0]),
    .is_signed (in_idle ? req_signed : signed_q),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .misalign  (misalign),
    .wstrb     (al_wstrb),
    .wdata_ext (al_wdata),
    .rdata_ext (al_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state. A flush only cancels what memory has not yet accepted; once
  // the address is accepted the data response must still be drained.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept && !misalign) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (mem_addr_ok)  state_next = flush ? ST_DRAIN : ST_WAIT;
        else if (flush)   state_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (mem_data_ok)  state_next = ST_IDLE;
        else if (flush)   state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (mem_data_ok)  state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Latched op. Loads carry zero strobes/data so the bus never sees
  // stale store lanes during a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      ea_q     <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      dst_q    <= '0;
      dstwe_q  <= 1'b0;
      store_q  <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
    end else if (accept && !misalign) begin
      ea_q     <= ea;
      size_q   <= req_size;
      signed_q <= req_signed;
      dst_q    <= req_dst;
      dstwe_q  <= req_dstwe;
      store_q  <= req_is_store;
      wstrb_q  <= req_is_store ? al_wstrb : 4'b0000;
      wdata_q  <= req_is_store ? al_wdata : 32'h0;
    end
  end

  assign load_done = (state == ST_WAIT) & mem_data_ok & ~flush & ~store_q & dstwe_q;

  // Writeback and exception pulses, registered one cycle after the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_dst       <= '0;
      wb_data      <= '0;
      exc_valid    <= 1'b0;
      exc_code     <= '0;
      exc_badvaddr <= '0;
    end else begin
      wb_valid  <= load_done;
      exc_valid <= accept & misalign;
      if (load_done) begin
        wb_dst  <= dst_q;
        wb_data <= al_rdata;
      end
      if (accept && misalign) begin
        exc_code     <= req_is_store ? EXC_ADES : EXC_ADEL;
        exc_badvaddr <= ea;
      end
    end
  end

  assign lsu_busy  = (state != ST_IDLE) | req_valid;
  assign mem_req   = (state == ST_REQ);
  assign mem_we    = store_q;
  assign mem_addr  = {ea_q[31:2], 2'b00};
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_pipe.sv
// tb_lsu_mem_pipe
//   Self-checking bench for lsu_mem_pipe: directed cases for the main
//   load/store/exception/flush behaviours, then randomized ops checked
//   against an arithmetic reference model of address, lanes and extension.
module tb_lsu_mem_pipe;
  localparam int PRF_W = 6;

  logic             clk = 1'b0;
  logic             rst, flush, req_valid, req_is_store, req_signed, req_dstwe;
  logic [1:0]       req_size;
  logic [31:0]      req_base, req_wdata;
  logic [15:0]      req_offset;
  logic [PRF_W-1:0] req_dst;
  logic             lsu_busy, mem_req, mem_we;
  logic [31:0]      mem_addr, mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_addr_ok, mem_data_ok;
  logic [31:0]      mem_rdata;
  logic             wb_valid, exc_valid;
  logic [PRF_W-1:0] wb_dst;
  logic [31:0]      wb_data, exc_badvaddr;
  logic [4:0]       exc_code;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_pipe #(.PRF_W(PRF_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_size(req_size),
    .req_signed(req_signed), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_dst(req_dst), .req_dstwe(req_dstwe),
    .lsu_busy(lsu_busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_badvaddr(exc_badvaddr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: sizes in bytes, natural alignment, lane arithmetic.
  function automatic int ref_bytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_ea(input logic [31:0] base, input logic [15:0] off);
    logic [31:0] s;
    s = {16'h0, off};
    if (off >= 16'h8000) s = s - 32'h0001_0000;
    return base + s;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] size, input logic [31:0] ea);
    int n;
    n = ref_bytes(size);
    return 4'(((1 << n) - 1) << (ea % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wd);
    int n;
    n = ref_bytes(size);
    if (n == 1) return {24'h0, wd[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'h0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                           input logic [31:0] ea, input logic [31:0] rd);
    int n;
    logic [31:0] v, mask;
    n = ref_bytes(size);
    v = rd >> (8 * (ea % 4));
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (sgn && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  task automatic apply_req(input logic st, input logic [1:0] size, input logic sgn,
                           input logic [31:0] base, input logic [15:0] off,
                           input logic [31:0] wd, input logic [PRF_W-1:0] dst, input logic dwe);
    req_valid = 1'b1; req_is_store = st; req_size = size; req_signed = sgn;
    req_base = base; req_offset = off; req_wdata = wd; req_dst = dst; req_dstwe = dwe;
    #1;
    check("busy_on_issue", lsu_busy, 1);
    tick;
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_base  = $urandom;
    #1;
  endtask

  // One full op with a responsive memory: aw cycles of addr_ok delay, dw
  // cycles of data delay after acceptance.
  task automatic run_op(input logic st, input logic [1:0] size, input logic sgn,
                        input logic [31:0] base, input logic [15:0] off,
                        input logic [31:0] wd, input logic [PRF_W-1:0] dst, input logic dwe,
                        input logic [31:0] rd, input int aw, input int dw);
    logic [31:0] ea;
    logic [3:0]  strb;
    ea = ref_ea(base, off);
    strb = st ? ref_strb(size, ea) : 4'b0000;
    apply_req(st, size, sgn, base, off, wd, dst, dwe);
    if ((ea % ref_bytes(size)) != 0) begin
      check("exc_valid", exc_valid, 1);
      check("exc_code", exc_code, st ? 5 : 4);
      check("exc_badvaddr", exc_badvaddr, ea);
      check("exc_no_req", mem_req, 0);
      check("exc_not_busy", lsu_busy, 0);
      tick;
      check("exc_pulse_end", exc_valid, 0);
      check("exc_no_req_later", mem_req, 0);
      return;
    end
    check("no_exc", exc_valid, 0);
    for (int i = 0; i <= aw; i++) begin
      check("mem_req", mem_req, 1);
      check("mem_addr", mem_addr, ea & 32'hFFFF_FFFC);
      check("mem_we", mem_we, st);
      check("mem_wstrb", mem_wstrb, strb);
      if (st) check("mem_wdata", mem_wdata, ref_wdata(size, wd));
      check("busy_req", lsu_busy, 1);
      if (i == aw) mem_addr_ok = 1'b1;
      tick;
      mem_addr_ok = 1'b0;
    end
    check("req_drop", mem_req, 0);
    repeat (dw) begin
      check("busy_wait", lsu_busy, 1);
      tick;
    end
    mem_data_ok = 1'b1;
    mem_rdata = rd;
    tick;
    mem_data_ok = 1'b0;
    mem_rdata = $urandom;
    check("wb_valid", wb_valid, (!st && dwe) ? 1 : 0);
    if (!st && dwe) begin
      check("wb_dst", wb_dst, dst);
      check("wb_data", wb_data, ref_load(size, sgn, ea, rd));
    end
    check("busy_done", lsu_busy, 0);
    tick;
    check("wb_pulse_end", wb_valid, 0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] base;
    logic [15:0] off;

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_base = '0; req_offset = '0; req_wdata = '0; req_dst = '0;
    req_dstwe = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    tick; tick;
    check("rst_busy", lsu_busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_exc_valid", exc_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_exc_code", exc_code, 0);
    rst = 1'b0;
    tick;

    // Directed loads, stores and address errors.
    run_op(0, 2'd2, 0, 32'h1000, 16'hFFFC, 32'h0, 6'd17, 1, 32'hDEADBEEF, 0, 0);
    run_op(0, 2'd0, 1, 32'h1000, 16'h0003, 32'h0, 6'd3,  1, 32'h80123456, 0, 0);
    run_op(0, 2'd0, 0, 32'h1000, 16'h0003, 32'h0, 6'd4,  1, 32'h80123456, 0, 1);
    run_op(0, 2'd1, 1, 32'h1002, 16'h0000, 32'h0, 6'd5,  1, 32'h9ABC0000, 1, 0);
    run_op(1, 2'd1, 0, 32'h2000, 16'h0002, 32'h1234ABCD, 6'd9, 1, 32'h0, 0, 1);
    run_op(1, 2'd0, 0, 32'h2001, 16'h0000, 32'h000000A5, 6'd9, 1, 32'h0, 0, 0);
    run_op(0, 2'd3, 0, 32'h4000, 16'h0008, 32'h0, 6'd6,  1, 32'h01020304, 0, 0);
    run_op(0, 2'd2, 0, 32'h3001, 16'h0000, 32'h0, 6'd7,  1, 32'h0, 0, 0);
    run_op(1, 2'd2, 0, 32'h3002, 16'h0000, 32'h0, 6'd7,  1, 32'h0, 0, 0);
    run_op(0, 2'd1, 0, 32'h3001, 16'h0000, 32'h0, 6'd7,  1, 32'h0, 0, 0);
    run_op(0, 2'd2, 0, 32'h5000, 16'h0000, 32'h0, 6'd8,  0, 32'h55555555, 0, 0);

    // Flush together with issue: op discarded, no bus or exception.
    flush = 1'b1;
    apply_req(0, 2'd2, 0, 32'h6000, 16'h0, 32'h0, 6'd1, 1);
    flush = 1'b0;
    check("flush_issue_req", mem_req, 0);
    check("flush_issue_busy", lsu_busy, 0);
    check("flush_issue_exc", exc_valid, 0);

    // addr_ok withheld 3 cycles, then flushed in REQ.
    apply_req(1, 2'd2, 0, 32'h7000, 16'h0010, 32'hCAFEF00D, 6'd2, 0);
    for (int i = 0; i < 3; i++) begin
      check("hold_req", mem_req, 1);
      check("hold_addr", mem_addr, 32'h7010);
      check("hold_wstrb", mem_wstrb, 4'hF);
      check("hold_wdata", mem_wdata, 32'hCAFEF00D);
      check("hold_busy", lsu_busy, 1);
      tick;
    end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush_req_drop", mem_req, 0);
    check("flush_req_idle", lsu_busy, 0);

    // Flush in WAIT; data arrives two cycles later and is discarded.
    apply_req(0, 2'd2, 0, 32'h8000, 16'h0, 32'h0, 6'd11, 1);
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("drain_busy1", lsu_busy, 1);
    check("drain_no_req", mem_req, 0);
    tick;
    check("drain_busy2", lsu_busy, 1);
    mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
    tick;
    mem_data_ok = 1'b0;
    check("drain_no_wb", wb_valid, 0);
    check("drain_done", lsu_busy, 0);

    // Flush in the same cycle as addr_ok: drain, no writeback.
    apply_req(0, 2'd2, 0, 32'h8100, 16'h0, 32'h0, 6'd12, 1);
    mem_addr_ok = 1'b1; flush = 1'b1;
    tick;
    mem_addr_ok = 1'b0; flush = 1'b0;
    check("ok_flush_busy", lsu_busy, 1);
    mem_data_ok = 1'b1;
    tick;
    mem_data_ok = 1'b0;
    check("ok_flush_no_wb", wb_valid, 0);
    check("ok_flush_idle", lsu_busy, 0);

    // Flush coinciding with data_ok in WAIT: straight to IDLE, no writeback.
    apply_req(0, 2'd2, 0, 32'h8200, 16'h0, 32'h0, 6'd13, 1);
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; flush = 1'b1;
    tick;
    mem_data_ok = 1'b0; flush = 1'b0;
    check("wait_flush_no_wb", wb_valid, 0);
    check("wait_flush_idle", lsu_busy, 0);

    // Reset in the middle of a transaction.
    apply_req(0, 2'd2, 0, 32'h9000, 16'h0, 32'h0, 6'd14, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_req", mem_req, 0);
    check("midrst_busy", lsu_busy, 0);

    // Randomized ops; two thirds are forced naturally aligned.
    for (int k = 0; k < 40; k++) begin
      sz   = 2'($urandom_range(0, 3));
      base = $urandom;
      off  = 16'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        off[1:0] = 2'b00;
        if (sz == 2'd1) base[0] = 1'b0;
        if (sz >= 2'd2) base[1:0] = 2'b00;
      end
      run_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), base, off,
             $urandom, 6'($urandom), ($urandom_range(0, 3) != 0), $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
